updown_counter_mod: RTL and testbench

//  Parametrised up/down counter with programmable modulus, run-time step and wrap/saturate mode.
//  Has synchronous clear and load, plus an integrated enable prescaler.

---
 rtl/counter_pkg.sv | 19 +
 rtl/count_prescaler.sv | 45 ++++
 rtl/updown_counter_mod.sv | 109 ++++++++++
 tb/tb_updown_counter_mod.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and parameter sanity helpers for the up/down counter
package counter_pkg;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   // True when the highest legal count is representable in the count register.
   function automatic bit max_val_fits(input int max_val, input int width);
      return (max_val >= 0) && (longint'(max_val) < (longint'(1) << width));
   endfunction

   // True when the largest step can never exceed one full modulus.
   function automatic bit step_fits(input int step_w, input int max_val);
      return ((longint'(1) << step_w) - 1) <= longint'(max_val);
   endfunction

endpackage

// File: rtl/count_prescaler.sv
// rtl/count_prescaler.sv - enable prescaler producing one advance tick per PRESCALE enabled cycles
module count_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic adv_tick
);

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("count_prescaler: PRESCALE must be >= 1");
   end

   if (PRESCALE == 1) begin : g_passthrough
      // No division needed: every enabled cycle is an advance.
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, reset, restart};
      assign adv_tick      = enable;
   end else begin : g_divider
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pre_cnt;
      logic          at_last;

      assign at_last  = (pre_cnt == LAST);
      assign adv_tick = enable & at_last;

      // Count enabled cycles, recycling to 0 on the advance cycle or on restart.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            pre_cnt <= '0;
         end else if (restart) begin
            pre_cnt <= '0;
         end else if (enable) begin
            pre_cnt <= at_last ? '0 : pre_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - up/down modulus counter with step, wrap/saturate mode and prescaler
module updown_counter_mod
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MAX_VAL  = 15,
   parameter int STEP_W   = 2,
   parameter int PRESCALE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_value,
   input  logic              enable,
   input  logic              up,
   input  logic [STEP_W-1:0] step,
   input  cnt_mode_e         mode,
   output logic [WIDTH-1:0]  count,
   output logic              event_pulse,
   output logic              at_max,
   output logic              at_min
);

   if (!max_val_fits(MAX_VAL, WIDTH)) begin : g_bad_max_val
      $error("updown_counter_mod: MAX_VAL must be < 2**WIDTH");
   end

   if (!step_fits(STEP_W, MAX_VAL)) begin : g_bad_step_w
      $error("updown_counter_mod: 2**STEP_W-1 must be <= MAX_VAL");
   end

   // One extra bit so count+step and count+modulus never overflow before comparing.
   localparam int EXT_W = WIDTH + 1;
   localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_VAL);
   localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MAX_VAL + 1);

   logic             adv_tick;
   logic [EXT_W-1:0] cur_ext;
   logic [EXT_W-1:0] step_ext;
   logic [EXT_W-1:0] sum_ext;
   logic [EXT_W-1:0] adv_ext;
   logic             adv_event;
   logic [EXT_W-1:0] load_ext;
   logic [WIDTH-1:0] load_clamped;

   count_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .restart  (clear | load),
      .adv_tick (adv_tick)
   );

   // Next count for an advance; a forced out-of-range count behaves as MAX_VAL.
   always_comb begin
      cur_ext   = ({1'b0, count} > MAX_EXT) ? MAX_EXT : {1'b0, count};
      step_ext  = EXT_W'(step);
      sum_ext   = cur_ext + step_ext;
      adv_ext   = cur_ext;
      adv_event = 1'b0;
      if (up) begin
         if (sum_ext <= MAX_EXT) begin
            adv_ext = sum_ext;
         end else begin
            adv_event = 1'b1;
            adv_ext   = (mode == CNT_SAT) ? MAX_EXT : sum_ext - MOD_EXT;
         end
      end else begin
         if (step_ext <= cur_ext) begin
            adv_ext = cur_ext - step_ext;
         end else begin
            adv_event = 1'b1;
            adv_ext   = (mode == CNT_SAT) ? '0 : cur_ext + MOD_EXT - step_ext;
         end
      end
   end

   // Loads above the modulus clamp to the highest legal count.
   always_comb begin
      load_ext     = {1'b0, load_value};
      load_clamped = (load_ext > MAX_EXT) ? WIDTH'(MAX_EXT) : load_value;
   end

   // Count register: reset > clear > load > advance; event lasts one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count       <= '0;
         event_pulse <= 1'b0;
      end else if (clear) begin
         count       <= '0;
         event_pulse <= 1'b0;
      end else if (load) begin
         count       <= load_clamped;
         event_pulse <= 1'b0;
      end else if (adv_tick) begin
         count       <= WIDTH'(adv_ext);
         event_pulse <= adv_event;
      end else begin
         event_pulse <= 1'b0;
      end
   end

   assign at_max = ({1'b0, count} == MAX_EXT);
   assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - scoreboard bench for updown_counter_mod, prescale 1 and 4
module tb_updown_counter_mod;
   import counter_pkg::*;

   localparam int WIDTH   = 4;
   localparam int MAX_VAL = 9;
   localparam int STEP_W  = 2;
   localparam int PRE [2] = '{1, 4};

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             clear = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_value = '0;
   logic             enable = 1'b0;
   logic             up = 1'b1;
   logic [1:0]       step = '0;
   cnt_mode_e        mode = CNT_WRAP;

   logic [WIDTH-1:0] count0, count1;
   logic             ev0, ev1, at_max0, at_max1, at_min0, at_min1;

   typedef struct {
      int c0;
      int e0;
      int c1;
      int e1;
   } exp_t;

   exp_t sb[$];
   int   m_cnt [2];
   int   m_ps  [2];
   int   m_ev  [2];
   int   n_checks = 0;
   int   n_fail   = 0;

   updown_counter_mod #(
      .WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .STEP_W(STEP_W), .PRESCALE(1)
   ) dut_p1 (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
      .enable(enable), .up(up), .step(step), .mode(mode),
      .count(count0), .event_pulse(ev0), .at_max(at_max0), .at_min(at_min0)
   );

   updown_counter_mod #(
      .WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .STEP_W(STEP_W), .PRESCALE(4)
   ) dut_p4 (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
      .enable(enable), .up(up), .step(step), .mode(mode),
      .count(count1), .event_pulse(ev1), .at_max(at_max1), .at_min(at_min1)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference: modular arithmetic on the count ring 0..MAX_VAL.
   function automatic int advance(input int c_in, input bit u, input int s,
                                  input cnt_mode_e md, output int ev);
      int c = (c_in > MAX_VAL) ? MAX_VAL : c_in;
      int raw = u ? c + s : c - s;
      ev = (raw > MAX_VAL || raw < 0) ? 1 : 0;
      if (ev == 0) return raw;
      if (md == CNT_SAT) return u ? MAX_VAL : 0;
      return ((raw % (MAX_VAL + 1)) + (MAX_VAL + 1)) % (MAX_VAL + 1);
   endfunction

   function automatic void model_cycle();
      for (int k = 0; k < 2; k++) begin
         m_ev[k] = 0;
         if (clear) begin
            m_cnt[k] = 0;
            m_ps[k]  = 0;
         end else if (load) begin
            m_cnt[k] = (int'(load_value) > MAX_VAL) ? MAX_VAL : int'(load_value);
            m_ps[k]  = 0;
         end else if (enable) begin
            if (m_ps[k] == PRE[k] - 1) begin
               m_ps[k]  = 0;
               m_cnt[k] = advance(m_cnt[k], up, int'(step), mode, m_ev[k]);
            end else begin
               m_ps[k] = m_ps[k] + 1;
            end
         end
      end
   endfunction

   task automatic drive(input bit clr, input bit ld, input int lv, input bit en,
                        input bit u, input int st, input cnt_mode_e md);
      exp_t e;
      @(negedge clk);
      clear      = clr;
      load       = ld;
      load_value = WIDTH'(lv);
      enable     = en;
      up         = u;
      step       = 2'(st);
      mode       = md;
      model_cycle();
      e.c0 = m_cnt[0];
      e.e0 = m_ev[0];
      e.c1 = m_cnt[1];
      e.e1 = m_ev[1];
      sb.push_back(e);
   endtask

   task automatic async_reset_check();
      @(negedge clk);
      clear  = 1'b0;
      load   = 1'b0;
      enable = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("async_reset_count_p1", int'(count0), 0);
      check("async_reset_count_p4", int'(count1), 0);
      check("async_reset_event_p1", int'(ev0), 0);
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0;
         m_ps[k]  = 0;
         m_ev[k]  = 0;
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: compare DUT outputs against the queued expectation after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("count_p1", int'(count0), e.c0);
            check("event_p1", int'(ev0), e.e0);
            check("at_max_p1", int'(at_max0), int'(e.c0 == MAX_VAL));
            check("at_min_p1", int'(at_min0), int'(e.c0 == 0));
            check("count_p4", int'(count1), e.c1);
            check("event_p4", int'(ev1), e.e1);
            check("at_max_p4", int'(at_max1), int'(e.c1 == MAX_VAL));
            check("at_min_p4", int'(at_min1), int'(e.c1 == 0));
         end
      end
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0;
         m_ps[k]  = 0;
         m_ev[k]  = 0;
      end
      #1;
      check("reset_count_p1", int'(count0), 0);
      check("reset_count_p4", int'(count1), 0);
      check("reset_event_p1", int'(ev0), 0);
      check("reset_at_min_p1", int'(at_min0), 1);
      check("reset_at_max_p1", int'(at_max0), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Up by 1 through the 9->0 wrap.
      for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, 1, 1, CNT_WRAP);
      // Wrap down from 0, then load 1 and step down by 3.
      drive(1, 0, 0, 0, 1, 1, CNT_WRAP);
      drive(0, 0, 0, 1, 0, 1, CNT_WRAP);
      drive(0, 1, 1, 0, 0, 3, CNT_WRAP);
      drive(0, 0, 0, 1, 0, 3, CNT_WRAP);
      // Saturation up, repeated clip at max, then saturation down.
      drive(0, 1, 7, 0, 1, 3, CNT_SAT);
      drive(0, 0, 0, 1, 1, 3, CNT_SAT);
      drive(0, 0, 0, 1, 1, 3, CNT_SAT);
      drive(0, 1, 1, 0, 0, 3, CNT_SAT);
      drive(0, 0, 0, 1, 0, 3, CNT_SAT);
      // Load clamp and priorities.
      drive(0, 1, 12, 0, 1, 1, CNT_WRAP);
      drive(0, 1, 3, 1, 1, 1, CNT_WRAP);
      drive(1, 1, 6, 1, 1, 1, CNT_WRAP);
      // Step 0 holds while the prescaler keeps recycling.
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1, 0, CNT_WRAP);
      // Prescale run with a two-cycle enable gap mid-prescale.
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 1, 1, CNT_WRAP);
      drive(0, 0, 0, 0, 1, 1, CNT_WRAP);
      drive(0, 0, 0, 0, 1, 1, CNT_WRAP);
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 1, 1, CNT_WRAP);
      // Asynchronous reset with count at 5, then restart.
      drive(0, 1, 5, 0, 1, 1, CNT_WRAP);
      async_reset_check();
      for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 1, 1, CNT_WRAP);

      // Randomized traffic, mode/up/step changing freely mid-prescale.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
               int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               cnt_mode_e'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
      #4;
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
